// File: rtl/vram_arbiter_if.sv
// vram_arbiter_if: scanout, CPU write, clear-control and RAM port signals of the frame-buffer arbiter
interface vram_arbiter_if #(
  parameter int AW = 14,
  parameter int DW = 12
);
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [DW-1:0] vga_data;
  logic          cpu_wr_valid;
  logic          cpu_wr_ready;
  logic [AW-1:0] cpu_wr_addr;
  logic [DW-1:0] cpu_wr_data;
  logic          clr_start;
  logic [DW-1:0] clr_color;
  logic          clr_busy;
  logic          clr_done;
  logic          ram_en;
  logic          ram_we;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  modport slave (
    input  vga_req, vga_addr, cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
           clr_start, clr_color, ram_rdata,
    output vga_data, cpu_wr_ready, clr_busy, clr_done,
           ram_en, ram_we, ram_addr, ram_wdata
  );
  modport master (
    output vga_req, vga_addr, cpu_wr_valid, cpu_wr_addr, cpu_wr_data,
           clr_start, clr_color, ram_rdata,
    input  vga_data, cpu_wr_ready, clr_busy, clr_done,
           ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port frame-buffer arbiter (scanout > CPU write buffer > clear sweep)
module vram_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int AW         = 14,
  parameter int DW         = 12
) (
  input logic          clk,
  input logic          rst_n,
  vram_arbiter_if.slave bus
);
  localparam int PW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, FLUSH, CLEAR} state_t;
  state_t        state_q, state_d;
  logic [AW-1:0] mem_a [FIFO_DEPTH];
  logic [DW-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [PW:0]   cnt_q, cnt_d;
  logic [AW-1:0] fill_q, fill_d, addr_q;
  logic [DW-1:0] color_q, color_d, wdata_q;
  logic          done_q, done_d;
  logic          empty, full, push, pop, vga_g, fill_g, last, start;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state_q <= IDLE;
    else state_q <= state_d;
  // next state and datapath next values; FLUSH hands over to CLEAR once the buffer drains
  always_comb begin
    start   = state_q == IDLE && bus.clr_start;
    last    = fill_g && &fill_q;
    cnt_d   = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    state_d = start ? (cnt_d == '0 ? CLEAR : FLUSH) :
              (state_q == FLUSH && cnt_d == '0) ? CLEAR :
              last ? IDLE : state_q;
    fill_d  = start ? '0 : fill_g ? fill_q + 1'b1 : fill_q;
    color_d = start ? bus.clr_color : color_q;
    done_d  = last;
  end
  // port grant and outputs; address/data hold their last value when nobody is granted
  always_comb begin
    empty            = cnt_q == '0;
    full             = cnt_q == (PW+1)'(FIFO_DEPTH);
    vga_g            = rst_n && bus.vga_req;
    pop              = !vga_g && !empty;
    fill_g           = !vga_g && empty && state_q == CLEAR;
    bus.cpu_wr_ready = !full && state_q == IDLE;
    push             = bus.cpu_wr_valid && bus.cpu_wr_ready;
    bus.ram_en       = vga_g || pop || fill_g;
    bus.ram_we       = pop || fill_g;
    bus.ram_addr     = vga_g ? bus.vga_addr : pop ? mem_a[rp_q] : fill_g ? fill_q : addr_q;
    bus.ram_wdata    = pop ? mem_d[rp_q] : fill_g ? color_q : wdata_q;
    bus.clr_busy     = state_q != IDLE;
    bus.clr_done     = done_q;
    bus.vga_data     = bus.ram_rdata;
  end
  // buffer pointers, fill counter, colour latch, done pulse and held RAM address/data
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt_q   <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      fill_q  <= '0;
      color_q <= '0;
      done_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      wp_q    <= wp_q + PW'(push);
      rp_q    <= rp_q + PW'(pop);
      fill_q  <= fill_d;
      color_q <= color_d;
      done_q  <= done_d;
      addr_q  <= bus.ram_addr;
      wdata_q <= bus.ram_wdata;
    end
  // write-buffer storage; contents are don't-care while the pointers say empty
  always_ff @(posedge clk)
    if (push) begin
      mem_a[wp_q] <= bus.cpu_wr_addr;
      mem_d[wp_q] <= bus.cpu_wr_data;
    end
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed vector table plus hand sequences for flush, clear sweep and reset abort
module tb_vram_arbiter;
  localparam int AW = 14;
  localparam int DW = 12;
  localparam int FD = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  vram_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  vram_arbiter #(.FIFO_DEPTH(FD), .AW(AW), .DW(DW)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );
  typedef struct {
    logic vga; logic [13:0] va;
    logic wv; logic [13:0] wa; logic [11:0] wd;
    logic cs; logic [11:0] cc; logic [11:0] rd;
    logic en; logic we; logic [13:0] addr; logic [11:0] wdata;
    logic rdy; logic busy; logic done;
  } vec_t;
  vec_t vt [16];
  int n_vec = 0;
  int n_bad = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic vga, input logic [13:0] va, input logic wv,
                       input logic [13:0] wa, input logic [11:0] wd,
                       input logic cs, input logic [11:0] cc);
    bus.vga_req      = vga;
    bus.vga_addr     = va;
    bus.cpu_wr_valid = wv;
    bus.cpu_wr_addr  = wa;
    bus.cpu_wr_data  = wd;
    bus.clr_start    = cs;
    bus.clr_color    = cc;
  endtask
  task automatic check_bus(input string tag, input logic en, input logic we,
                           input logic [13:0] addr, input logic [11:0] wdata,
                           input logic rdy, input logic busy, input logic done);
    chk({tag, "_en"}, 32'(bus.ram_en), 32'(en));
    chk({tag, "_we"}, 32'(bus.ram_we), 32'(we));
    chk({tag, "_addr"}, 32'(bus.ram_addr), 32'(addr));
    chk({tag, "_wdata"}, 32'(bus.ram_wdata), 32'(wdata));
    chk({tag, "_ready"}, 32'(bus.cpu_wr_ready), 32'(rdy));
    chk({tag, "_busy"}, 32'(bus.clr_busy), 32'(busy));
    chk({tag, "_done"}, 32'(bus.clr_done), 32'(done));
  endtask
  task automatic idle_cycle();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0);
    #1;
  endtask
  // runs the clear sweep from address first for n writes; optional 10-cycle scanout burst at vga_at
  task automatic sweep(input int first, input int n, input logic [11:0] col, input int vga_at,
                       output int bad, output int writes, output int reads);
    int exp_a = first;
    int cyc = 0;
    bad = 0;
    writes = 0;
    reads = 0;
    while (writes < n && cyc < n + 100) begin
      @(negedge clk);
      cyc++;
      if (exp_a == vga_at && reads < 10) begin
        drive(1, 14'(14'h3000 + reads), 0, 0, 0, 0, 0);
        #1;
        if (!(bus.ram_en && !bus.ram_we && bus.ram_addr == 14'(14'h3000 + reads) &&
              bus.clr_busy && !bus.clr_done)) bad++;
        reads++;
      end else begin
        drive(0, 0, exp_a == first + 60, 14'h3FF0, 12'hBAD, exp_a == first + 50, 12'hFFF);
        #1;
        if (!(bus.ram_en && bus.ram_we && bus.ram_addr == 14'(exp_a) && bus.ram_wdata == col &&
              bus.clr_busy && !bus.clr_done && !bus.cpu_wr_ready)) bad++;
        exp_a++;
        writes++;
      end
    end
  endtask
  initial begin
    int bad, wr, rd;
    vt[0]  = '{0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 14'h0000, 12'h000, 1, 0, 0};
    vt[1]  = '{0, 0, 1, 14'h0081, 12'hF00, 0, 0, 12'h000, 0, 0, 14'h0000, 12'h000, 1, 0, 0};
    vt[2]  = '{0, 0, 0, 0, 0, 0, 0, 12'h000, 1, 1, 14'h0081, 12'hF00, 1, 0, 0};
    vt[3]  = '{0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 14'h0081, 12'hF00, 1, 0, 0};
    vt[4]  = '{1, 14'h1234, 0, 0, 0, 0, 0, 12'hABC, 1, 0, 14'h1234, 12'hF00, 1, 0, 0};
    vt[5]  = '{1, 14'h0010, 1, 14'h0100, 12'h001, 0, 0, 12'h111, 1, 0, 14'h0010, 12'hF00, 1, 0, 0};
    vt[6]  = '{1, 14'h0011, 1, 14'h0101, 12'h002, 0, 0, 12'h222, 1, 0, 14'h0011, 12'hF00, 1, 0, 0};
    vt[7]  = '{1, 14'h0012, 1, 14'h0102, 12'h003, 0, 0, 12'h333, 1, 0, 14'h0012, 12'hF00, 1, 0, 0};
    vt[8]  = '{1, 14'h0013, 1, 14'h0103, 12'h004, 0, 0, 12'h444, 1, 0, 14'h0013, 12'hF00, 1, 0, 0};
    vt[9]  = '{1, 14'h0014, 1, 14'h0104, 12'h005, 0, 0, 12'h555, 1, 0, 14'h0014, 12'hF00, 0, 0, 0};
    vt[10] = '{0, 0, 1, 14'h0104, 12'h005, 0, 0, 12'h000, 1, 1, 14'h0100, 12'h001, 0, 0, 0};
    vt[11] = '{0, 0, 1, 14'h0104, 12'h005, 0, 0, 12'h000, 1, 1, 14'h0101, 12'h002, 1, 0, 0};
    vt[12] = '{0, 0, 0, 0, 0, 0, 0, 12'h000, 1, 1, 14'h0102, 12'h003, 1, 0, 0};
    vt[13] = '{0, 0, 0, 0, 0, 0, 0, 12'h000, 1, 1, 14'h0103, 12'h004, 1, 0, 0};
    vt[14] = '{0, 0, 0, 0, 0, 0, 0, 12'h000, 1, 1, 14'h0104, 12'h005, 1, 0, 0};
    vt[15] = '{0, 0, 0, 0, 0, 0, 0, 12'h000, 0, 0, 14'h0104, 12'h005, 1, 0, 0};
    drive(0, 0, 0, 0, 0, 0, 0);
    bus.ram_rdata = '0;
    repeat (2) @(negedge clk);
    #1;
    check_bus("reset", 0, 0, 14'h0000, 12'h000, 1, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      drive(vt[i].vga, vt[i].va, vt[i].wv, vt[i].wa, vt[i].wd, vt[i].cs, vt[i].cc);
      bus.ram_rdata = vt[i].rd;
      #1;
      check_bus($sformatf("v%0d", i), vt[i].en, vt[i].we, vt[i].addr, vt[i].wdata,
                vt[i].rdy, vt[i].busy, vt[i].done);
      chk($sformatf("v%0d_vga_data", i), 32'(bus.vga_data), 32'(vt[i].rd));
    end
    bus.ram_rdata = '0;
    // two writes buffered behind scanout, third push on the clr_start cycle, then flush and full sweep
    @(negedge clk); drive(1, 14'h0020, 1, 14'h0200, 12'h111, 0, 0); #1;
    check_bus("fl_p0", 1, 0, 14'h0020, 12'h005, 1, 0, 0);
    @(negedge clk); drive(1, 14'h0021, 1, 14'h0201, 12'h222, 0, 0); #1;
    check_bus("fl_p1", 1, 0, 14'h0021, 12'h005, 1, 0, 0);
    @(negedge clk); drive(1, 14'h0022, 1, 14'h0202, 12'h333, 1, 12'h0F0); #1;
    check_bus("fl_start", 1, 0, 14'h0022, 12'h005, 1, 0, 0);
    @(negedge clk); drive(0, 0, 1, 14'h3FF0, 12'hBAD, 0, 0); #1;
    check_bus("fl_d0", 1, 1, 14'h0200, 12'h111, 0, 1, 0);
    @(negedge clk); drive(0, 0, 1, 14'h3FF0, 12'hBAD, 0, 0); #1;
    check_bus("fl_d1", 1, 1, 14'h0201, 12'h222, 0, 1, 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1;
    check_bus("fl_d2", 1, 1, 14'h0202, 12'h333, 0, 1, 0);
    sweep(0, 16384, 12'h0F0, 100, bad, wr, rd);
    chk("sweep_bad_cycles", 32'(bad), 0);
    chk("sweep_writes", 32'(wr), 16384);
    chk("sweep_vga_reads", 32'(rd), 10);
    idle_cycle();
    check_bus("sweep_done", 0, 0, 14'h3FFF, 12'h0F0, 1, 0, 1);
    idle_cycle();
    check_bus("sweep_after", 0, 0, 14'h3FFF, 12'h0F0, 1, 0, 0);
    // reset while flushing discards the buffered writes
    @(negedge clk); drive(1, 14'h0030, 1, 14'h0300, 12'h777, 0, 0);
    @(negedge clk); drive(1, 14'h0031, 1, 14'h0301, 12'h888, 1, 12'h123);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1;
    check_bus("rf_flush", 1, 1, 14'h0300, 12'h777, 0, 1, 0);
    @(negedge clk); rst_n = 1'b0; #1;
    check_bus("rf_in_reset", 0, 0, 14'h0000, 12'h000, 1, 0, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check_bus("rf_release", 0, 0, 14'h0000, 12'h000, 1, 0, 0);
    idle_cycle();
    check_bus("rf_after", 0, 0, 14'h0000, 12'h000, 1, 0, 0);
    // direct clear with empty buffer, aborted by reset at counter 5000, then restarted
    @(negedge clk); drive(0, 0, 0, 0, 0, 1, 12'h00F); #1;
    check_bus("ca_start", 0, 0, 14'h0000, 12'h000, 1, 0, 0);
    sweep(0, 5000, 12'h00F, -1, bad, wr, rd);
    chk("abort_bad_cycles", 32'(bad), 0);
    chk("abort_writes", 32'(wr), 5000);
    @(negedge clk); drive(0, 0, 0, 0, 0, 0, 0); #1;
    check_bus("ca_at5000", 1, 1, 14'd5000, 12'h00F, 0, 1, 0);
    #1 rst_n = 1'b0; #1;
    check_bus("ca_in_reset", 0, 0, 14'h0000, 12'h000, 1, 0, 0);
    @(negedge clk); rst_n = 1'b1; #1;
    check_bus("ca_release", 0, 0, 14'h0000, 12'h000, 1, 0, 0);
    bad = 0;
    repeat (3) begin
      idle_cycle();
      if (bus.clr_done || bus.ram_en || bus.clr_busy) bad++;
    end
    chk("ca_no_done", 32'(bad), 0);
    @(negedge clk); drive(0, 0, 0, 0, 0, 1, 12'h0AA); #1;
    check_bus("cr_start", 0, 0, 14'h0000, 12'h000, 1, 0, 0);
    sweep(0, 20, 12'h0AA, -1, bad, wr, rd);
    chk("restart_bad_cycles", 32'(bad), 0);
    chk("restart_writes", 32'(wr), 20);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: CPU write-buffer depth in entries (power of two, >=2).
REQ-002 Parameter AW, default 14: frame-buffer address width ({row[6:0], col[6:0]}, 128x128 pixels).
REQ-003 Parameter DW, default 12: pixel width ({r[3:0], g[3:0], b[3:0]}).
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 vga_req  input  1  scanout needs the RAM this cycle (pixel inside display window).
REQ-007 vga_addr  input  AW  scanout pixel address.
REQ-008 vga_data  output  DW  scanout pixel data, direct pass-through of ram_rdata.
REQ-009 cpu_wr_valid  input  1  CPU presents a pixel write.
REQ-010 cpu_wr_ready  output  1  block accepts the write this cycle.
REQ-011 cpu_wr_addr  input  AW  CPU write address.
REQ-012 cpu_wr_data  input  DW  CPU write pixel.
REQ-013 clr_start  input  1  single-cycle request to fill the whole frame buffer with clr_color.
REQ-014 clr_color  input  DW  fill colour, sampled on the clr_start cycle.
REQ-015 clr_busy  output  1  high from clr_start acceptance until the fill completes.
REQ-016 clr_done  output  1  one-cycle pulse after the last fill write.
REQ-017 ram_en, ram_we  output  1 each  single-port RAM enable and write enable.
REQ-018 ram_addr  output  AW;  ram_wdata  output  DW;  ram_rdata  input  DW (synchronous-read RAM, 1-cycle latency).

Function
REQ-019 Port grant per cycle, fixed priority: vga_req > FIFO drain > fill sweep; exactly one requester is granted per cycle, or none.
REQ-020 VGA grant: ram_en=1, ram_we=0, ram_addr=vga_addr, combinational from inputs; scanout is never stalled.
REQ-021 Drain grant (FIFO non-empty, vga_req=0): ram_en=1, ram_we=1, addr/data = FIFO head; head popped in the same cycle.
REQ-022 Fill grant (state CLEAR, FIFO empty, vga_req=0): ram_en=1, ram_we=1, ram_addr=fill counter, ram_wdata=latched colour; counter increments after the granted write.
REQ-023 No grant: ram_en=0, ram_we=0; ram_addr and ram_wdata hold their previous values.
REQ-024 FIFO: in-order, FIFO_DEPTH entries; push on cpu_wr_valid && cpu_wr_ready; simultaneous push and pop leaves occupancy unchanged.
REQ-025 cpu_wr_ready = (FIFO not full) && (state == IDLE); a full FIFO or non-IDLE state back-pressures the CPU, so no write is dropped.
REQ-026 FSM states IDLE, FLUSH, CLEAR.
REQ-027 IDLE --clr_start, FIFO empty--> CLEAR; IDLE --clr_start, FIFO non-empty--> FLUSH; colour is latched and the counter is set to 0 on either transition.
REQ-028 FLUSH --FIFO empty--> CLEAR; buffered CPU writes therefore always land before the fill begins.
REQ-029 CLEAR --granted write at address 2^AW-1--> IDLE; clr_done=1 in the following cycle only.
REQ-030 clr_busy=1 in FLUSH and CLEAR, 0 in IDLE.
REQ-031 clr_start outside IDLE is ignored; the colour and counter are unchanged.
REQ-032 A fill write issued while vga_req=1 is deferred, not skipped; the counter does not advance without a grant.
REQ-033 A push arriving on the same cycle as an IDLE clr_start is accepted and flushed before the fill.

Reset
REQ-034 rst_n low asynchronously forces: state IDLE, FIFO empty, fill counter 0, latched colour 0, clr_done 0, ram_en 0, ram_we 0, ram_addr 0, ram_wdata 0.
REQ-035 Reset during FLUSH or CLEAR aborts the operation, discards FIFO contents and produces no clr_done pulse.
REQ-036 After release, cpu_wr_ready=1 and clr_busy=0 from the first cycle.

Verification
REQ-037 Write addr 0x0081 data 0xF00 with vga_req=0 -> ram_we=1, ram_addr=0x0081, ram_wdata=0xF00 one cycle after acceptance.
REQ-038 Hold vga_req=1 and push 5 writes (depth 4) -> 4 accepted, cpu_wr_ready=0 on the 5th, no RAM write; drop vga_req -> 4 writes in order over 4 cycles, then the 5th is accepted.
REQ-039 clr_start colour 0x0F0 with 2 writes buffered -> FLUSH writes the 2 entries, then addresses 0..16383 are written 0x0F0, clr_done pulses once, clr_busy is low afterwards.
REQ-040 During CLEAR, assert vga_req for 10 cycles at counter 100 -> 10 VGA reads and counter held at 100; the fill resumes at 100 with no gaps.
REQ-041 Assert rst_n low at counter 5000 in CLEAR -> state IDLE, clr_busy=0, no clr_done; a fresh clr_start restarts from address 0.
